// File: rtl/seq_detect_prog_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encoding and the cfg_len width derivation.
package seq_detect_prog_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_FILL_ENC = 2'd1;
  localparam logic [1:0] ST_HUNT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_FILL = ST_FILL_ENC,
    ST_HUNT = ST_HUNT_ENC
  } state_t;

  // Bits needed to hold a length in 0..max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector: Mealy match output,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_prog
  import seq_detect_prog_pkg::*;
#(
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 16,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int               HIST_W    = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  state_t             r_state;
  logic [HIST_W-1:0]  r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   r_len;
  logic [MAX_LEN-1:0] r_pattern;
  logic               r_overlap;

  logic [HIST_W:0]    w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [LEN_W-1:0]   w_len_m1;
  logic               w_cfg_legal;
  logic               w_hit;

  // Newest bit sits at the LSB, so the last len bits line up with pattern[len-1:0].
  assign w_window    = {r_hist, x};
  assign w_fill_inc  = r_fill + ONE_L;
  assign w_len_m1    = r_len - ONE_L;
  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  // NOTE: the default assignment before the loop guarantees no latch is inferred.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_hit = (((w_window[MAX_LEN-1:0] ^ r_pattern) & w_mask) == '0);
  assign match = (r_state == ST_HUNT) && x_valid && !cfg_load && w_hit;
  assign armed = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_len     <= '0;
      r_pattern <= '0;
      r_overlap <= 1'b0;
    end else if (cfg_load) begin
      // An illegal length disarms but keeps the previously stored config.
      if (w_cfg_legal) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
        r_state   <= (cfg_len == ONE_L) ? ST_HUNT : ST_FILL;
      end else begin
        r_state <= ST_IDLE;
      end
    end else if (x_valid) begin
      case (r_state)
        ST_FILL: begin
          r_hist <= w_window[HIST_W-1:0];
          r_fill <= w_fill_inc;
          if (w_fill_inc >= w_len_m1) begin
            r_state <= ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (match && !r_overlap) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= (r_len == ONE_L) ? ST_HUNT : ST_FILL;
          end else begin
            r_hist <= w_window[HIST_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_inc(match),
    .i_clr(cnt_clr),
    .o_cnt(match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: table-driven stream vectors plus
// hand-written corner sequences, with a match scoreboard queue.
module tb_seq_detect_prog;

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       b;
    logic       clr;
    logic       m;
    int         armed;
    int         cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        armed, match;
  logic [15:0] match_cnt;
  logic        armed2, match2;
  logic [1:0]  match_cnt2;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .armed(armed), .match(match), .match_cnt(match_cnt)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .armed(armed2), .match(match2), .match_cnt(match_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                              input logic ovl, input logic v, input logic b, input logic clr,
                              input logic m, input int armed_e, input int cnt_e);
    vec_t r;
    r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl; r.v = v; r.b = b;
    r.clr = clr; r.m = m; r.armed = armed_e; r.cnt = cnt_e;
    return r;
  endfunction

  // One clock cycle: drive just after the rising edge, check on the falling edge.
  task automatic cycle(input vec_t c, input string tag);
    @(posedge clk);
    #1;
    cfg_load = c.ld; cfg_pattern = c.pat; cfg_len = c.len; cfg_overlap = c.ovl;
    x_valid = c.v; x = c.b; cnt_clr = c.clr;
    exp_q.push_back(c.m);
    @(negedge clk);
    check($sformatf("%s match", tag), int'(match), int'(exp_q.pop_front()));
    if (c.armed >= 0) check($sformatf("%s armed", tag), int'(armed), c.armed);
    if (c.cnt >= 0) check($sformatf("%s match_cnt", tag), int'(match_cnt), c.cnt);
  endtask

  task automatic bit_in(input logic b, input logic m, input string tag);
    cycle(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, m, -1, -1), tag);
  endtask

  task automatic idle(input int armed_e, input int cnt_e, input string tag);
    cycle(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, armed_e, cnt_e), tag);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input string tag);
    cycle(mk(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1), tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1; cfg_load = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    check($sformatf("%s armed", tag), int'(armed), 0);
    check($sformatf("%s match_cnt", tag), int'(match_cnt), 0);
    check($sformatf("%s match_cnt2", tag), int'(match_cnt2), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Tests 1-3: 1001 non-overlap, 1001 overlap, len=1, then illegal lengths.
    tbl.push_back(mk(1, 8'h09, 4, 0, 0, 0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0,  1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1,  1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0,  1,  1));
    tbl.push_back(mk(1, 8'h09, 4, 1, 0, 0, 1, 0, -1,  1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, -1,  0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1,  1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0,  1,  2));
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 0, 1, 0, -1,  2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1,  1,  0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, -1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0,  1,  3));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0,  1,  3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0,  0, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0,  0, -1));
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0, 0,  0, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0,  1, -1));
    tbl.push_back(mk(1, 8'h01, 9, 0, 0, 0, 0, 0,  1, -1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0,  0,  3));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset armed", int'(armed), 0);
    check("reset match", int'(match), 0);
    check("reset match_cnt", int'(match_cnt), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Test 4: 2-bit counter saturates; clear wins over a simultaneous match.
    pulse_reset("t4 reset");
    load(8'h03, 4'd2, 1'b1, "t4 load");
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1, (i > 0), $sformatf("t4 bit%0d", i));
      check($sformatf("t4 bit%0d match2", i), int'(match2), int'(i > 0));
    end
    idle(1, 7, "t4 after");
    check("t4 armed2", int'(armed2), 1);
    check("t4 sat match_cnt2", int'(match_cnt2), 3);
    cycle(mk(0, 8'h00, 0, 0, 1, 1, 1, 1, -1, -1), "t4 clr+match");
    idle(-1, 0, "t4 cleared");
    check("t4 cleared match_cnt2", int'(match_cnt2), 0);

    // Test 5: cfg_load together with x_valid drops the bit and discards history.
    pulse_reset("t5 reset");
    load(8'h09, 4'd4, 1'b0, "t5 load1001");
    bit_in(1'b1, 1'b0, "t5 b1");
    bit_in(1'b0, 1'b0, "t5 b2");
    bit_in(1'b0, 1'b0, "t5 b3");
    cycle(mk(1, 8'h05, 3, 0, 1, 1, 0, 0, 1, -1), "t5 load101+bit");
    bit_in(1'b1, 1'b0, "t5 c1");
    bit_in(1'b0, 1'b0, "t5 c2");
    bit_in(1'b1, 1'b1, "t5 c3");
    idle(1, 1, "t5 after");

    // Test 6: reset mid-stream clears count and config; nothing matches until reload.
    load(8'h09, 4'd4, 1'b0, "t6 load1001");
    bit_in(1'b1, 1'b0, "t6 b1");
    bit_in(1'b0, 1'b0, "t6 b2");
    bit_in(1'b0, 1'b0, "t6 b3");
    pulse_reset("t6 reset");
    bit_in(1'b1, 1'b0, "t6 post1");
    bit_in(1'b0, 1'b0, "t6 post2");
    bit_in(1'b0, 1'b0, "t6 post3");
    bit_in(1'b1, 1'b0, "t6 post4");
    idle(0, 0, "t6 after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
